// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two-requester round-robin arbiter feeding a single
// registered output slot (1-cycle latency, one beat per cycle).
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (A wins ties).
module mux2_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] data_reg;
  logic             src_reg;
  logic             can_load;
  logic             grant_a;
  logic             grant_b;
  logic             sel;

`ifndef ARB_FIXED_PRIO_EN
  // 1 = A was granted last, 0 = B was granted last
  logic             last_grant_reg;
`endif

  assign out_valid = (state_reg == FULL);
  assign out_data  = data_reg;
  assign out_src   = src_reg;

  // Grant selection: the slot can take a beat when empty or draining now
  always_comb begin
    can_load = (state_reg == EMPTY) | (out_valid & out_ready);
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    if (can_load) begin
`ifdef ARB_FIXED_PRIO_EN
      grant_a = a_valid;
      grant_b = b_valid & ~a_valid;
`else
      grant_a = a_valid & (~b_valid | ~last_grant_reg);
      grant_b = b_valid & (~a_valid |  last_grant_reg);
`endif
    end
    a_ready = grant_a;
    b_ready = grant_b;
    sel     = grant_a;
  end

  // Next-state: any grant fills the slot, a drain without grant empties it
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: begin
        if (grant_a | grant_b) state_next = FULL;
      end
      FULL: begin
        if (out_ready && !(grant_a | grant_b)) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Output payload and source capture; held when no grant occurs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
      src_reg  <= 1'b0;
    end else if (grant_a | grant_b) begin
      data_reg <= sel ? a_data : b_data;
      src_reg  <= sel;
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  // Round-robin history: only real grants move it; reset favours A first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b0;
    end else if (grant_a | grant_b) begin
      last_grant_reg <= grant_a;
    end
  end
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Testbench for mux2_rr_arbiter: directed vector table plus a hand-written
// asynchronous-reset sequence.
module tb_mux2_rr_arbiter;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;

  int n_vec;
  int n_fail;
  int n_checks;

  typedef struct {
    logic             av;
    logic [WIDTH-1:0] ad;
    logic             bv;
    logic [WIDTH-1:0] bd;
    logic             ordy;
    logic             e_ar;
    logic             e_br;
    logic             e_ov;
    logic [WIDTH-1:0] e_od;
    logic             e_os;
  } vec_t;

  vec_t vecs[$];

  mux2_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic av, logic [WIDTH-1:0] ad, logic bv,
                              logic [WIDTH-1:0] bd, logic ordy, logic e_ar,
                              logic e_br, logic e_ov, logic [WIDTH-1:0] e_od,
                              logic e_os);
    vec_t v;
    v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.ordy = ordy;
    v.e_ar = e_ar; v.e_br = e_br; v.e_ov = e_ov; v.e_od = e_od; v.e_os = e_os;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies one vector starting just after a rising edge: readies are checked
  // before the next edge, registered outputs just after it.
  task automatic apply(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    a_valid = v.av; a_data = v.ad; b_valid = v.bv; b_data = v.bd;
    out_ready = v.ordy;
    #1;
    check({tag, ".a_ready"}, 32'(a_ready), 32'(v.e_ar));
    check({tag, ".b_ready"}, 32'(b_ready), 32'(v.e_br));
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v.e_ov));
    check({tag, ".out_data"}, 32'(out_data), 32'(v.e_od));
    check({tag, ".out_src"}, 32'(out_src), 32'(v.e_os));
    n_vec++;
    $display("%s: a=%b/%h b=%b/%h ordy=%b -> rdy %b%b out %b/%h/%b", tag,
             v.av, v.ad, v.bv, v.bd, v.ordy, a_ready, b_ready, out_valid,
             out_data, out_src);
  endtask

  initial begin
    n_vec = 0; n_fail = 0; n_checks = 0;
    rst_n = 1'b0;
    a_valid = 1'b0; a_data = '0; b_valid = 1'b0; b_data = '0;
    out_ready = 1'b0;

    //        av  ad     bv  bd     ordy ar br ov od     os
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0)); // idle
    vecs.push_back(mk(1, 8'h3C, 0, 8'h00, 1, 1, 0, 1, 8'h3C, 1)); // single A
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h3C, 1)); // drain, hold data
    vecs.push_back(mk(0, 8'h00, 1, 8'h11, 1, 0, 1, 1, 8'h11, 0)); // single B
    vecs.push_back(mk(0, 8'h00, 1, 8'h22, 0, 0, 0, 1, 8'h11, 0)); // backpressure
    vecs.push_back(mk(0, 8'h00, 1, 8'h22, 0, 0, 0, 1, 8'h11, 0));
    vecs.push_back(mk(0, 8'h00, 1, 8'h22, 0, 0, 0, 1, 8'h11, 0));
    vecs.push_back(mk(0, 8'h00, 1, 8'h22, 1, 0, 1, 1, 8'h22, 0)); // release
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h22, 0)); // drain
`ifdef ARB_FIXED_PRIO_EN
    vecs.push_back(mk(1, 8'hAA, 1, 8'h55, 1, 1, 0, 1, 8'hAA, 1)); // contention
    vecs.push_back(mk(1, 8'hAA, 1, 8'h55, 1, 1, 0, 1, 8'hAA, 1));
    vecs.push_back(mk(1, 8'hAA, 1, 8'h55, 1, 1, 0, 1, 8'hAA, 1));
    vecs.push_back(mk(1, 8'hAA, 1, 8'h55, 1, 1, 0, 1, 8'hAA, 1));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'hAA, 1)); // drain
`else
    vecs.push_back(mk(1, 8'hAA, 1, 8'h55, 1, 1, 0, 1, 8'hAA, 1)); // contention
    vecs.push_back(mk(1, 8'hAA, 1, 8'h55, 1, 0, 1, 1, 8'h55, 0));
    vecs.push_back(mk(1, 8'hAA, 1, 8'h55, 1, 1, 0, 1, 8'hAA, 1));
    vecs.push_back(mk(1, 8'hAA, 1, 8'h55, 1, 0, 1, 1, 8'h55, 0));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h55, 0)); // drain
`endif

    // Reset, then idle
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_data", 32'(out_data), 32'h00);
    check("reset.out_src", 32'(out_src), 32'd0);
    check("reset.a_ready", 32'(a_ready), 32'd0);
    check("reset.b_ready", 32'(b_ready), 32'd0);
    n_vec++;
    $display("reset: out %b/%h/%b rdy %b%b", out_valid, out_data, out_src,
             a_ready, b_ready);

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Reset mid-operation: load 8'h77 from A (so last grant is A), then
    // assert rst_n between edges and confirm the tie afterwards goes to A.
    a_valid = 1'b1; a_data = 8'h77; b_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("midrst.loaded_valid", 32'(out_valid), 32'd1);
    check("midrst.loaded_data", 32'(out_data), 32'h77);
    a_valid = 1'b0; out_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("midrst.async_valid", 32'(out_valid), 32'd0);
    check("midrst.async_data", 32'(out_data), 32'h00);
    check("midrst.async_src", 32'(out_src), 32'd0);
    n_vec++;
    $display("midrst: during reset out %b/%h/%b", out_valid, out_data, out_src);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b1; a_data = 8'hAA; b_valid = 1'b1; b_data = 8'h55;
    out_ready = 1'b1;
    #1;
    check("midrst.tie_a_ready", 32'(a_ready), 32'd1);
    check("midrst.tie_b_ready", 32'(b_ready), 32'd0);
    @(posedge clk);
    #1;
    check("midrst.tie_data", 32'(out_data), 32'hAA);
    check("midrst.tie_src", 32'(out_src), 32'd1);
    n_vec++;
    $display("midrst: first tie after reset -> out %b/%h/%b", out_valid,
             out_data, out_src);
    a_valid = 1'b0; b_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Shares one WIDTH-bit output channel between two requesters (A, B) using an internal 2:1 select, where sel=1 picks A and sel=0 picks B.
- Round-robin arbitration; valid/ready handshake on all three channels.
- One-entry registered output stage: 1-cycle latency, full throughput.
- Sits in front of any shared single-port consumer (bus, register file write port, display driver).

Parameters:
WIDTH, 8, data width of both inputs and the output

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
a_valid  input  1  requester A has data
a_data  input  WIDTH  requester A payload
a_ready  output  1  A transfer accepted this cycle (a_valid & a_ready)
b_valid  input  1  requester B has data
b_data  input  WIDTH  requester B payload
b_ready  output  1  B transfer accepted this cycle
out_valid  output  1  output register holds data
out_data  output  WIDTH  registered payload
out_src  output  1  source of out_data: 1=A, 0=B
out_ready  input  1  consumer accepts when out_valid & out_ready

Behaviour:
- Reset: asynchronous on rst_n low.
  - Values held during reset: out_valid=0, out_data=0, out_src=0, last_grant=B (so A wins the first tie), state=EMPTY.
  - Any held data is discarded, including on a reset mid-transfer.
- State machine, registered:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_load = (state==EMPTY) | (out_valid & out_ready). Combinational; a same-cycle drain frees the slot.
- Grant selection (combinational, only when can_load=1):
  - Only a_valid: grant A.
  - Only b_valid: grant B.
  - Both valid: grant the requester not equal to last_grant.
  - Neither valid: no grant.
- a_ready = can_load & grant_A; b_ready = can_load & grant_B. The two are never high in the same cycle.
- ready may depend combinationally on valid; valid must not depend on ready.
- On a grant (rising edge):
  - out_data <= sel ? a_data : b_data; out_src <= sel.
  - last_grant <= granted requester; state -> FULL.
- Transitions:
  - FULL with out_ready=1 and no grant: -> EMPTY. out_data and out_src hold their last values.
  - FULL with out_ready=0: hold everything; both readies stay 0 (backpressure).
  - FULL with out_ready=1 and a grant: stays FULL with new data (back-to-back, 1 beat/cycle).
- Latency: input handshake at edge N → out_valid and data visible after edge N.
- Fairness: with both requesters held valid and out_ready=1, grants alternate A,B,A,B… A requester never waits more than one grant.
- last_grant updates only on an actual grant, not on idle cycles.
- Data width: straight copy, no arithmetic, no truncation; all buses are WIDTH bits.
- Requester protocol: a requester may drop valid before it is accepted. The arbiter stores nothing unless a ready was high.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority, A always wins ties. last_grant is not used (may be removed). Starvation of B is permitted by design.
- Not defined: round-robin as specified above.
- Ports and timing are identical in both builds.

Test Plan:
- Reset, then idle → after rst_n rises: out_valid=0, out_data=8'h00, a_ready=b_ready=0.
- Single A beat: a_valid=1, a_data=8'h3C, out_ready=1 for one cycle → a_ready=1 in that cycle; next cycle out_valid=1, out_data=8'h3C, out_src=1.
- Contention: A=8'hAA and B=8'h55 both held valid, out_ready=1 for 4 cycles → output sequence AA,55,AA,55; out_src 1,0,1,0; one grant per cycle.
  - With ARB_FIXED_PRIO_EN defined: AA,AA,AA,AA and b_ready never 1.
- Backpressure: output FULL with 8'h11, out_ready=0 for 3 cycles while b_valid=1 → out_data stays 8'h11; b_ready=0 throughout. out_ready=1 → b_ready=1 in the same cycle, B data appears next cycle.
- Reset mid-operation: output FULL with 8'h77, rst_n pulled low between clock edges → out_valid=0 immediately (asynchronous). After release, first tie goes to A.
- Drain without refill: FULL, out_ready=1, no valids → next cycle out_valid=0 and out_data keeps its last value.
